atm_ledger_arbiter: RTL and testbench
=====================================

Name: atm_ledger_arbiter

Overview:
Shared account-ledger controller that serialises transactions from several ATM session front-ends onto one account-balance store. Holds the balance array and grants one requester at a time by round-robin. Each granted transaction runs as a read-check-write sequence: balance query, deposit, withdraw or transfer, with a funds and overflow check before any write. Sits between the per-terminal session FSMs and the ledger storage; it is the only writer of balances.

Parameters:
NUM_REQ, 2, number of requesting ATM sessions (2..4)
NUM_ACCTS, 4, number of accounts in the ledger (power of 2)
BAL_W, 12, balance width, unsigned
AMT_W, 8, transaction amount width, unsigned

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  NUM_REQ  per-requester transaction request
req_ready  out  NUM_REQ  one-hot accept; a transfer happens when valid&ready
req_op  in  2*NUM_REQ  per-requester op: 00 BALANCE, 01 DEPOSIT, 10 WITHDRAW, 11 TRANSFER
req_src  in  log2(NUM_ACCTS)*NUM_REQ  source/own account index
req_dst  in  log2(NUM_ACCTS)*NUM_REQ  destination index (TRANSFER only)
req_amount  in  AMT_W*NUM_REQ  amount (ignored for BALANCE)
rsp_valid  out  NUM_REQ  one-hot, 1-cycle response pulse to the owning requester
rsp_status  out  2  00 OK, 01 INSUFFICIENT, 10 OVERFLOW, 11 BAD_DST
rsp_balance  out  BAL_W  source balance after the transaction (unchanged on error)
init_we  in  1  ledger preload write strobe
init_idx  in  log2(NUM_ACCTS)  preload account index
init_bal  in  BAL_W  preload balance
busy  out  1  high in every state except IDLE
txn_count  out  16  count of OK transactions, wraps at 16'hFFFF to 0

Behaviour:
- Reset: all balances 0, FSM IDLE, rr pointer 0. req_ready, rsp_valid, rsp_status, rsp_balance, busy and txn_count are all 0.
- FSM states: IDLE -> READ -> EXEC -> RESP -> IDLE, one cycle each.
- IDLE:
  - If init_we=1, write init_bal to init_idx. No grant this cycle; preload has priority.
  - Otherwise, if any req_valid is set, the round-robin arbiter drives req_ready one-hot for the winner in the same cycle (combinational from req_valid and the pointer).
  - Latch the winner's op, src, dst and amount. Move the pointer to winner+1 mod NUM_REQ. Go to READ.
- init_we outside IDLE is ignored.
- READ: capture bal_src=ledger[src] and bal_dst=ledger[dst].
- EXEC, evaluated with BAL_W+1-bit intermediates:
  - BALANCE: always OK, no write.
  - DEPOSIT: if bal_src+amount > 2^BAL_W-1, status OVERFLOW with no write. Else write the sum, OK.
  - WITHDRAW: if amount > bal_src, INSUFFICIENT with no write. Else write the difference, OK. amount == bal_src is legal and yields 0.
  - TRANSFER:
    - If dst==src, BAD_DST.
    - Else if amount > bal_src, INSUFFICIENT.
    - Else if bal_dst+amount overflows, OVERFLOW.
    - Else write both src and dst in the same cycle, OK.
    - Any error means neither account is written.
  - Amount 0 is legal: OK, balances unchanged.
- RESP: rsp_valid pulses on the winner's bit for 1 cycle; rsp_status and rsp_balance are valid only in that cycle. txn_count increments when status is OK.
- Latency: accept at cycle T gives rsp_valid at T+3. The next accept is possible at T+4.
- A requester must hold req_valid and its fields stable until accepted. Dropping valid before ready is legal; no transaction occurs.
- Reset mid-transaction: the sequence aborts and no partial write occurs. Balances return to 0 per reset.
- Simultaneous valids: exactly one grant, and the lowest index at or after the pointer wins.

Decomposition:
- Shared package atm_pkg holds:
  - op codes (OP_BALANCE..OP_TRANSFER)
  - status codes (ST_OK, ST_INSUFF, ST_OVF, ST_BAD_DST)
  - FSM state encoding
  - the default widths
- Sub-module atm_rr_arbiter, parameterised by NUM_REQ. Inputs: valid vector, pointer, enable. Outputs: one-hot grant and winner index. Purely combinational; the pointer register stays in the parent.

Test Plan:
- Preload acct0=100, acct1=50. Req0 DEPOSIT 20 on acct0 -> rsp_valid[0] at T+3, OK, rsp_balance=120, txn_count=1.
- acct1=50. Req1 WITHDRAW 60 -> INSUFFICIENT, balance 50; a following BALANCE on acct1 returns 50, and txn_count is unchanged.
- acct0=120, acct1=50. TRANSFER 120 from acct0 to acct1 -> OK, rsp_balance=0; a BALANCE on acct1 returns 170.
- TRANSFER src=dst=2 -> BAD_DST. DEPOSIT 10 on a balance of 4090 (BAL_W=12) -> OVERFLOW, balance stays 4090.
- Req0 and req1 held valid continuously -> grants alternate 0,1,0,1. init_we asserted while busy -> ignored. init_we in IDLE with req_valid set -> no req_ready that cycle.
- Assert rst during EXEC of WITHDRAW 10 on a balance of 30 -> no rsp_valid, all outputs 0, a BALANCE after preload-free restart returns 0.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared definitions for the ATM ledger arbiter: opcodes, status codes,
// controller state encoding and default widths.
package atm_pkg;

    localparam int DEF_NUM_REQ   = 2;
    localparam int DEF_NUM_ACCTS = 4;
    localparam int DEF_BAL_W     = 12;
    localparam int DEF_AMT_W     = 8;

    typedef enum logic [1:0] {
        OP_BALANCE  = 2'b00,
        OP_DEPOSIT  = 2'b01,
        OP_WITHDRAW = 2'b10,
        OP_TRANSFER = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_INSUFF  = 2'b01,
        ST_OVF     = 2'b10,
        ST_BAD_DST = 2'b11
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_READ = 2'b01,
        S_EXEC = 2'b10,
        S_RESP = 2'b11
    } state_e;

endpackage

// File: rtl/atm_rr_arbiter.sv
// Combinational round-robin picker: the lowest valid index at or after the
// pointer wins. The pointer register itself lives in the parent.
module atm_rr_arbiter
    import atm_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int RI_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [RI_W-1:0]    ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [RI_W-1:0]    winner
);

    // Rotating a doubled copy puts the pointer position at bit 0, so the
    // first set bit of the rotated vector is the distance to the winner.
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    int                   pick;
    logic                 found;

    assign dbl = {valid, valid};
    assign rot = NUM_REQ'(dbl >> ptr);

    // Find the nearest requester after the pointer and build the one-hot grant
    always_comb begin
        pick   = 0;
        found  = 1'b0;
        winner = '0;
        grant  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                pick  = int'(ptr) + k;
            end
        end
        if (pick >= NUM_REQ) begin
            pick = pick - NUM_REQ;
        end
        if (enable && found) begin
            winner = RI_W'(pick);
            for (int j = 0; j < NUM_REQ; j++) begin
                grant[j] = (winner == RI_W'(j));
            end
        end
    end

endmodule

// File: rtl/atm_ledger_arbiter.sv
// Ledger controller: owns the account balances, grants one ATM session at a
// time and runs each transaction as read -> check/execute -> respond.
module atm_ledger_arbiter
    import atm_pkg::*;
#(
    parameter  int NUM_REQ   = DEF_NUM_REQ,
    parameter  int NUM_ACCTS = DEF_NUM_ACCTS,
    parameter  int BAL_W     = DEF_BAL_W,
    parameter  int AMT_W     = DEF_AMT_W,
    localparam int IDX_W     = $clog2(NUM_ACCTS),
    localparam int RI_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [2*NUM_REQ-1:0]     req_op,
    input  logic [IDX_W*NUM_REQ-1:0] req_src,
    input  logic [IDX_W*NUM_REQ-1:0] req_dst,
    input  logic [AMT_W*NUM_REQ-1:0] req_amount,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [1:0]               rsp_status,
    output logic [BAL_W-1:0]         rsp_balance,
    input  logic                     init_we,
    input  logic [IDX_W-1:0]         init_idx,
    input  logic [BAL_W-1:0]         init_bal,
    output logic                     busy,
    output logic [15:0]              txn_count
);

    state_e             state_reg;
    logic [RI_W-1:0]    ptr_reg;
    logic [RI_W-1:0]    owner_reg;
    op_e                op_reg;
    logic [IDX_W-1:0]   src_reg;
    logic [IDX_W-1:0]   dst_reg;
    logic [AMT_W-1:0]   amt_reg;
    logic [BAL_W-1:0]   bal_src_reg;
    logic [BAL_W-1:0]   bal_dst_reg;
    logic [NUM_REQ-1:0] rsp_valid_reg;
    status_e            rsp_status_reg;
    logic [BAL_W-1:0]   rsp_balance_reg;
    logic               busy_reg;
    logic [15:0]        txn_count_reg;
    logic [BAL_W-1:0]   ledger_reg [NUM_ACCTS];

    // Per-requester views of the packed request buses
    op_e              op_arr  [NUM_REQ];
    logic [IDX_W-1:0] src_arr [NUM_REQ];
    logic [IDX_W-1:0] dst_arr [NUM_REQ];
    logic [AMT_W-1:0] amt_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign op_arr[gi]  = op_e'(req_op[2*gi +: 2]);
            assign src_arr[gi] = req_src[IDX_W*gi +: IDX_W];
            assign dst_arr[gi] = req_dst[IDX_W*gi +: IDX_W];
            assign amt_arr[gi] = req_amount[AMT_W*gi +: AMT_W];
        end
    endgenerate

    // Preload owns the IDLE cycle, so arbitration is suppressed while init_we is high
    logic               arb_enable;
    logic [NUM_REQ-1:0] grant;
    logic [RI_W-1:0]    winner;
    logic [RI_W-1:0]    ptr_next;

    assign arb_enable = (state_reg == S_IDLE) && !init_we;
    assign ptr_next   = (winner == RI_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

    atm_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .valid  (req_valid),
        .ptr    (ptr_reg),
        .enable (arb_enable),
        .grant  (grant),
        .winner (winner)
    );

    // One extra bit on every intermediate catches overflow and borrow
    logic [BAL_W:0]   amt_ext;
    logic [BAL_W:0]   src_ext;
    logic [BAL_W:0]   src_sum;
    logic [BAL_W:0]   src_diff;
    logic [BAL_W:0]   dst_sum;
    status_e          exec_status;
    logic [BAL_W-1:0] new_src;
    logic [BAL_W-1:0] new_dst;
    logic             wr_src;
    logic             wr_dst;

    assign amt_ext  = {{(BAL_W + 1 - AMT_W){1'b0}}, amt_reg};
    assign src_ext  = {1'b0, bal_src_reg};
    assign src_sum  = src_ext + amt_ext;
    assign src_diff = src_ext - amt_ext;
    assign dst_sum  = {1'b0, bal_dst_reg} + amt_ext;

    // Evaluate the latched operation against the captured balances; any error blocks all writes
    always_comb begin
        exec_status = ST_OK;
        new_src     = bal_src_reg;
        new_dst     = bal_dst_reg;
        wr_src      = 1'b0;
        wr_dst      = 1'b0;
        case (op_reg)
            OP_BALANCE: begin
                exec_status = ST_OK;
            end
            OP_DEPOSIT: begin
                if (src_sum[BAL_W]) begin
                    exec_status = ST_OVF;
                end else begin
                    new_src = src_sum[BAL_W-1:0];
                    wr_src  = 1'b1;
                end
            end
            OP_WITHDRAW: begin
                if (amt_ext > src_ext) begin
                    exec_status = ST_INSUFF;
                end else begin
                    new_src = src_diff[BAL_W-1:0];
                    wr_src  = 1'b1;
                end
            end
            OP_TRANSFER: begin
                if (dst_reg == src_reg) begin
                    exec_status = ST_BAD_DST;
                end else if (amt_ext > src_ext) begin
                    exec_status = ST_INSUFF;
                end else if (dst_sum[BAL_W]) begin
                    exec_status = ST_OVF;
                end else begin
                    new_src = src_diff[BAL_W-1:0];
                    new_dst = dst_sum[BAL_W-1:0];
                    wr_src  = 1'b1;
                    wr_dst  = 1'b1;
                end
            end
            default: begin
                exec_status = ST_OK;
            end
        endcase
    end

    // Ledger storage: preload only in IDLE, transaction writes only in EXEC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ACCTS; i++) begin
                ledger_reg[i] <= '0;
            end
        end else if (state_reg == S_EXEC) begin
            if (wr_src) begin
                ledger_reg[src_reg] <= new_src;
            end
            if (wr_dst) begin
                ledger_reg[dst_reg] <= new_dst;
            end
        end else if ((state_reg == S_IDLE) && init_we) begin
            ledger_reg[init_idx] <= init_bal;
        end
    end

    // Transaction sequencer with registered response, busy and counter outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            ptr_reg         <= '0;
            owner_reg       <= '0;
            op_reg          <= OP_BALANCE;
            src_reg         <= '0;
            dst_reg         <= '0;
            amt_reg         <= '0;
            bal_src_reg     <= '0;
            bal_dst_reg     <= '0;
            rsp_valid_reg   <= '0;
            rsp_status_reg  <= ST_OK;
            rsp_balance_reg <= '0;
            busy_reg        <= 1'b0;
            txn_count_reg   <= '0;
        end else begin
            rsp_valid_reg   <= '0;
            rsp_status_reg  <= ST_OK;
            rsp_balance_reg <= '0;
            case (state_reg)
                S_IDLE: begin
                    if (|grant) begin
                        owner_reg <= winner;
                        op_reg    <= op_arr[winner];
                        src_reg   <= src_arr[winner];
                        dst_reg   <= dst_arr[winner];
                        amt_reg   <= amt_arr[winner];
                        ptr_reg   <= ptr_next;
                        busy_reg  <= 1'b1;
                        state_reg <= S_READ;
                    end
                end
                S_READ: begin
                    bal_src_reg <= ledger_reg[src_reg];
                    bal_dst_reg <= ledger_reg[dst_reg];
                    state_reg   <= S_EXEC;
                end
                S_EXEC: begin
                    rsp_valid_reg   <= NUM_REQ'(1) << owner_reg;
                    rsp_status_reg  <= exec_status;
                    rsp_balance_reg <= new_src;
                    if (exec_status == ST_OK) begin
                        txn_count_reg <= txn_count_reg + 16'd1;
                    end
                    state_reg <= S_RESP;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = grant;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_status  = rsp_status_reg;
    assign rsp_balance = rsp_balance_reg;
    assign busy        = busy_reg;
    assign txn_count   = txn_count_reg;

endmodule

// File: tb/tb_atm_ledger_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic checked
// against a plain-arithmetic ledger model.
module tb_atm_ledger_arbiter;
    import atm_pkg::*;

    localparam int NR   = 2;
    localparam int NA   = 4;
    localparam int BW   = 12;
    localparam int AW   = 8;
    localparam int IW   = 2;
    localparam int MAXB = (1 << BW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req_valid;
    logic [NR-1:0] req_ready;
    logic [2*NR-1:0] req_op;
    logic [IW*NR-1:0] req_src;
    logic [IW*NR-1:0] req_dst;
    logic [AW*NR-1:0] req_amount;
    logic [NR-1:0] rsp_valid;
    logic [1:0]    rsp_status;
    logic [BW-1:0] rsp_balance;
    logic          init_we;
    logic [IW-1:0] init_idx;
    logic [BW-1:0] init_bal;
    logic          busy;
    logic [15:0]   txn_count;

    atm_ledger_arbiter #(.NUM_REQ(NR), .NUM_ACCTS(NA), .BAL_W(BW), .AMT_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_src     (req_src),
        .req_dst     (req_dst),
        .req_amount  (req_amount),
        .rsp_valid   (rsp_valid),
        .rsp_status  (rsp_status),
        .rsp_balance (rsp_balance),
        .init_we     (init_we),
        .init_idx    (init_idx),
        .init_bal    (init_bal),
        .busy        (busy),
        .txn_count   (txn_count)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int mbal [NA];
    int mcount;
    int mptr;

    // Per-requester stimulus fields
    int t_op  [NR];
    int t_src [NR];
    int t_dst [NR];
    int t_amt [NR];
    logic [NR-1:0] t_valid;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int r = 0; r < NR; r++) begin
            req_op[2*r +: 2]      = 2'(t_op[r]);
            req_src[IW*r +: IW]   = IW'(t_src[r]);
            req_dst[IW*r +: IW]   = IW'(t_dst[r]);
            req_amount[AW*r +: AW] = AW'(t_amt[r]);
        end
        req_valid = t_valid;
    endtask

    task automatic set_req(input int r, input int op, input int s, input int d, input int a);
        t_op[r]  = op;
        t_src[r] = s;
        t_dst[r] = d;
        t_amt[r] = a;
    endtask

    function automatic int model_winner(input logic [NR-1:0] mask);
        for (int k = 0; k < NR; k++) begin
            if (mask[(mptr + k) % NR]) return (mptr + k) % NR;
        end
        return -1;
    endfunction

    // Apply the ledger rules with ordinary integer arithmetic
    function automatic void model_exec(input int op, input int s, input int d, input int a,
                                       output int st, output int rb);
        int bs;
        int bd;
        bs = mbal[s];
        bd = mbal[d];
        st = 0;
        if (op == 1) begin
            if (bs + a > MAXB) st = 2;
            else mbal[s] = bs + a;
        end else if (op == 2) begin
            if (a > bs) st = 1;
            else mbal[s] = bs - a;
        end else if (op == 3) begin
            if (s == d) st = 3;
            else if (a > bs) st = 1;
            else if (bd + a > MAXB) st = 2;
            else begin
                mbal[s] = bs - a;
                mbal[d] = bd + a;
            end
        end
        rb = mbal[s];
        if (st == 0) mcount = (mcount + 1) % 65536;
    endfunction

    task automatic preload(input int idx, input int val);
        init_we  = 1'b1;
        init_idx = IW'(idx);
        init_bal = BW'(val);
        @(negedge clk);
        init_we = 1'b0;
        mbal[idx] = val;
    endtask

    // One full transaction starting at a negedge with the controller idle
    task automatic txn(input logic [NR-1:0] mask, input bit drop, input bit poke_busy);
        int w;
        int n;
        int est;
        int erb;
        t_valid = mask;
        drive();
        #1;
        w = model_winner(mask);
        n = 0;
        while (req_ready == '0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("grant", int'(req_ready), 1 << w);
        if (n >= 20) return;
        chk("busy_idle", int'(busy), 0);
        model_exec(t_op[w], t_src[w], t_dst[w], t_amt[w], est, erb);
        mptr = (w + 1) % NR;
        @(posedge clk);
        #1;
        if (drop) begin
            t_valid = '0;
            drive();
        end
        @(negedge clk);
        chk("rsp_early_read", int'(rsp_valid), 0);
        chk("busy_read", int'(busy), 1);
        if (poke_busy) begin
            init_we  = 1'b1;
            init_idx = 2'd3;
            init_bal = 12'd999;
        end
        @(negedge clk);
        init_we = 1'b0;
        chk("rsp_early_exec", int'(rsp_valid), 0);
        @(negedge clk);
        chk("rsp_valid", int'(rsp_valid), 1 << w);
        chk("rsp_status", int'(rsp_status), est);
        chk("rsp_balance", int'(rsp_balance), erb);
        @(negedge clk);
        chk("txn_count", int'(txn_count), mcount);
        chk("rsp_pulse_end", int'(rsp_valid), 0);
        $display("txn req%0d op=%0d src=%0d dst=%0d amt=%0d -> status=%0d bal=%0d count=%0d",
                 w, t_op[w], t_src[w], t_dst[w], t_amt[w], rsp_status, erb, txn_count);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        init_we = 1'b0;
        init_idx = '0;
        init_bal = '0;
        t_valid = '0;
        for (int r = 0; r < NR; r++) set_req(r, 0, 0, 0, 0);
        drive();
        for (int i = 0; i < NA; i++) mbal[i] = 0;
        mcount = 0;
        mptr = 0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_txn_count", int'(txn_count), 0);
        chk("reset_rsp_status", int'(rsp_status), 0);
        chk("reset_rsp_balance", int'(rsp_balance), 0);
        chk("reset_req_ready", int'(req_ready), 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic deposit / withdraw / transfer sequence
        preload(0, 100);
        preload(1, 50);
        set_req(0, 1, 0, 0, 20);    txn(2'b01, 1, 0);
        set_req(1, 2, 1, 0, 60);    txn(2'b10, 1, 0);
        set_req(1, 0, 1, 0, 0);     txn(2'b10, 1, 0);
        set_req(0, 3, 0, 1, 120);   txn(2'b01, 1, 0);
        set_req(1, 0, 1, 0, 0);     txn(2'b10, 1, 0);
        chk("balance_after_transfer", int'(rsp_balance), 0);
        set_req(0, 3, 2, 2, 5);     txn(2'b01, 1, 0);
        preload(3, 4090);
        set_req(1, 1, 3, 0, 10);    txn(2'b10, 1, 0);

        // Both requesters held valid: grants must alternate
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) txn(2'b11, 0, 0);
        t_valid = '0;
        drive();
        @(negedge clk);

        // Preload attempted while busy is ignored
        set_req(0, 0, 0, 0, 0);     txn(2'b01, 1, 1);
        set_req(1, 0, 3, 0, 0);     txn(2'b10, 1, 0);

        // Preload in IDLE beats a pending request for that cycle
        set_req(0, 0, 2, 0, 0);
        t_valid = 2'b01;
        drive();
        init_we = 1'b1;
        init_idx = 2'd2;
        init_bal = 12'd77;
        #1;
        chk("ready_blocked_by_init", int'(req_ready), 0);
        @(negedge clk);
        init_we = 1'b0;
        mbal[2] = 77;
        txn(2'b01, 1, 0);

        // Reset during EXEC of a withdraw aborts without writing
        preload(2, 30);
        set_req(0, 2, 2, 0, 10);
        t_valid = 2'b01;
        drive();
        #1;
        chk("abort_grant", int'(req_ready), 1);
        @(posedge clk);
        #1;
        t_valid = '0;
        drive();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_rsp_valid", int'(rsp_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_txn_count", int'(txn_count), 0);
        chk("abort_rsp_status", int'(rsp_status), 0);
        chk("abort_rsp_balance", int'(rsp_balance), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NA; i++) mbal[i] = 0;
        mcount = 0;
        mptr = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", int'(rsp_valid), 0);
        end
        set_req(1, 0, 2, 0, 0);     txn(2'b10, 1, 0);

        // Randomized traffic against the model
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                preload(int'($urandom_range(0, NA - 1)),
                        ($urandom_range(0, 1) == 1) ? int'($urandom_range(MAXB - 300, MAXB))
                                                    : int'($urandom_range(0, 400)));
            end
            for (int r = 0; r < NR; r++) begin
                set_req(r, int'($urandom_range(0, 3)), int'($urandom_range(0, NA - 1)),
                        int'($urandom_range(0, NA - 1)),
                        ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, (1 << AW) - 1)));
            end
            txn(NR'($urandom_range(1, (1 << NR) - 1)), 1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
